// File: rtl/display_source_arbiter_pkg.sv
// Shared OLED display constants and types for the display source arbiter.
package disp_pkg;

    localparam int OLED_W       = 96;
    localparam int OLED_H       = 64;
    localparam int FRAME_PIXELS = OLED_W * OLED_H;
    localparam int IDX_W        = 13;
    localparam int RGB_W        = 16;

    typedef logic [RGB_W-1:0] rgb565_t;

    localparam rgb565_t BLACK  = 16'h0000;
    localparam rgb565_t WHITE  = 16'hFFFF;
    localparam rgb565_t RED    = 16'hF800;
    localparam rgb565_t GREEN  = 16'h07E0;
    localparam rgb565_t YELLOW = 16'hFFE0;

    typedef enum logic {
        IDLE,
        GRANTED
    } arb_state_t;

endpackage

// File: rtl/display_source_arbiter_if.sv
// Pixel port shared between the OLED driver, the renderers and the arbiter.
interface display_source_arbiter_if #(
    parameter int N_SRC = 3
);
    import disp_pkg::*;

    logic [IDX_W-1:0]       pixel_index;
    logic [N_SRC-1:0]       req;
    logic [RGB_W*N_SRC-1:0] src_data;
    rgb565_t                oled_data;
    logic [N_SRC-1:0]       grant;
    logic [2:0]             grant_id;
    logic                   frame_tick;

    modport master (
        output pixel_index, req, src_data,
        input  oled_data, grant, grant_id, frame_tick
    );

    modport slave (
        input  pixel_index, req, src_data,
        output oled_data, grant, grant_id, frame_tick
    );

endinterface

// File: rtl/display_source_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req at or after start.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   start,
    output logic         found,
    output logic [2:0]   idx
);

    int k;

    // Walk offsets high to low so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= N) k = k - N;
            if (req[k]) begin
                found = 1'b1;
                idx   = 3'(k);
            end
        end
    end

endmodule

// File: rtl/display_source_arbiter.sv
// Frame-granular round-robin arbiter muxing renderer pixels onto the OLED port.
module display_source_arbiter
    import disp_pkg::*;
#(
    parameter int          N_SRC        = 3,
    parameter int          FRAME_PIXELS = disp_pkg::FRAME_PIXELS,
    parameter int          DWELL_FRAMES = 30,
    parameter logic [15:0] BLANK_COLOUR = 16'h0000
) (
    input logic                     CLOCK,
    input logic                     RESET_N,
    display_source_arbiter_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_PIXELS - 1);
    localparam logic [2:0]       TOP  = 3'(N_SRC - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] prev_index;
    logic [7:0]       dwell_cnt;
    logic [2:0]       rr_ptr;
    logic [2:0]       start;
    logic [2:0]       pick;
    logic             found;
    logic             frame_end;
    logic             req_cur;
    logic             take;
    logic             drop;
    rgb565_t          pix;

    assign frame_end = (bus.pixel_index == LAST) && (prev_index != LAST);
    assign req_cur   = |(bus.req & bus.grant);

    // Masking the current grant turns the picker into "next other requester".
    assign start = (state == GRANTED)
                 ? ((bus.grant_id == TOP) ? 3'd0 : bus.grant_id + 3'd1)
                 : rr_ptr;

    rr_pick #(.N(N_SRC)) u_pick (
        .req   (bus.req & ~bus.grant),
        .start (start),
        .found (found),
        .idx   (pick)
    );

    always_comb begin
        take = 1'b0;
        drop = 1'b0;
        unique case (state)
            IDLE: take = found;
            GRANTED: begin
                if (!req_cur) begin
                    take = found;
                    drop = !found;
                end else begin
                    take = found && (dwell_cnt >= 8'(DWELL_FRAMES - 1));
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pix = BLANK_COLOUR;
        for (int k = 0; k < N_SRC; k++)
            if (bus.grant[k]) pix = bus.src_data[16*k +: 16];
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state          <= IDLE;
            prev_index     <= '0;
            dwell_cnt      <= '0;
            rr_ptr         <= '0;
            bus.grant      <= '0;
            bus.grant_id   <= '0;
            bus.oled_data  <= BLANK_COLOUR;
            bus.frame_tick <= 1'b0;
        end else begin
            prev_index     <= bus.pixel_index;
            bus.frame_tick <= frame_end;
            bus.oled_data  <= pix;
            if (frame_end) begin
                if (take) begin
                    state        <= GRANTED;
                    bus.grant    <= N_SRC'(1) << pick;
                    bus.grant_id <= pick;
                    dwell_cnt    <= '0;
                    rr_ptr       <= (pick == TOP) ? 3'd0 : pick + 3'd1;
                end else if (drop) begin
                    state        <= IDLE;
                    bus.grant    <= '0;
                    bus.grant_id <= '0;
                    dwell_cnt    <= '0;
                end else if (state == GRANTED && dwell_cnt != 8'hFF) begin
                    dwell_cnt <= dwell_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter with DWELL_FRAMES=3.
module tb_display_source_arbiter;
    import disp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ticks;
    logic [15:0] src [3];
    logic [2:0]  exp_g [7];

    always #5 clk = ~clk;

    display_source_arbiter_if #(.N_SRC(3)) bus();

    display_source_arbiter #(
        .N_SRC        (3),
        .FRAME_PIXELS (6144),
        .DWELL_FRAMES (3),
        .BLANK_COLOUR (16'h0000)
    ) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    assign bus.src_data = {src[2], src[1], src[0]};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int p);
        bus.pixel_index = 13'(p);
        tick();
    endtask

    function automatic logic [15:0] colour(input logic [2:0] g);
        return g[0] ? src[0] : g[1] ? src[1] : g[2] ? src[2] : 16'h0000;
    endfunction

    initial begin
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b001};
        src[0] = GREEN;
        src[1] = RED;
        src[2] = YELLOW;
        bus.req = 3'b000;
        bus.pixel_index = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_grant", bus.grant, 3'b000);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_oled", bus.oled_data, 16'h0000);
        chk("rst_tick", bus.frame_tick, 0);
        chk("rst_dwell", dut.dwell_cnt, 0);

        // 1: idle for two full frames
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 6144; p++) begin
                pix(p);
                chk("t1_px", {bus.grant, bus.oled_data}, 0);
            end
            chk("t1_tick", bus.frame_tick, 1);
        end

        // 2: request raised mid-frame
        for (int p = 0; p < 10; p++) begin
            pix(p);
            chk("t2_pre", {bus.grant, bus.oled_data}, 0);
        end
        bus.req = 3'b010;
        for (int p = 3000; p < 3010; p++) begin
            pix(p);
            chk("t2_mid", {bus.grant, bus.oled_data}, 0);
        end
        pix(6142);
        chk("t2_6142", {bus.grant, bus.oled_data}, 0);
        pix(6143);
        chk("t2_grant", bus.grant, 3'b010);
        chk("t2_gid", bus.grant_id, 1);
        chk("t2_last_blank", bus.oled_data, 16'h0000);
        chk("t2_tick", bus.frame_tick, 1);
        for (int p = 0; p < 6; p++) begin
            pix(p);
            chk("t2_oled", bus.oled_data, 16'hF800);
            chk("t2_tick0", bus.frame_tick, 0);
        end

        // 3: dwell rotation between src0 and src1
        bus.pixel_index = 13'd5;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req = 3'b011;
        src[1] = 16'h001F;
        pix(6143);
        chk("t3_first", bus.grant, 3'b001);
        for (int k = 0; k < 7; k++) begin
            foreach (exp_g[j]) if (j < 5) begin
                pix((j < 3) ? j : (j == 3) ? 3000 : 6142);
                chk("t3_grant", bus.grant, exp_g[k]);
                chk("t3_oled", bus.oled_data, colour(exp_g[k]));
            end
            if (k < 6) begin
                pix(6143);
                chk("t3_no_tear", bus.oled_data, colour(exp_g[k]));
                chk("t3_tick", bus.frame_tick, 1);
                chk("t3_next", bus.grant, exp_g[k+1]);
            end
        end

        // 4: src2 drops its request mid-frame while src0 waits
        bus.req = 3'b100;
        pix(6143);
        chk("t4_grant2", bus.grant, 3'b100);
        chk("t4_gid2", bus.grant_id, 2);
        bus.req = 3'b101;
        ticks = 0;
        for (int p = 0; p < 6144; p++) begin
            if (p == 3000) bus.req = 3'b001;
            pix(p);
            chk("t4_oled", bus.oled_data, 16'hFFE0);
            ticks += int'(bus.frame_tick);
        end
        chk("t4_ticks", ticks, 1);
        chk("t4_grant0", bus.grant, 3'b001);
        chk("t4_gid0", bus.grant_id, 0);
        pix(0);
        chk("t4_oled0", bus.oled_data, 16'h07E0);

        // 5: last index held, then out-of-range indices
        pix(100);
        chk("t5_dwell0", dut.dwell_cnt, 0);
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            pix(6143);
            ticks += int'(bus.frame_tick);
        end
        chk("t5_ticks", ticks, 1);
        chk("t5_dwell1", dut.dwell_cnt, 1);
        chk("t5_grant", bus.grant, 3'b001);
        pix(0);
        chk("t5_tick0", bus.frame_tick, 0);
        bus.req = 3'b010;
        pix(6144);
        chk("t5_oor_tick_a", bus.frame_tick, 0);
        pix(8191);
        chk("t5_oor_tick_b", bus.frame_tick, 0);
        pix(7000);
        chk("t5_oor_tick_c", bus.frame_tick, 0);
        chk("t5_oor_grant", bus.grant, 3'b001);
        pix(6143);
        chk("t5_switch", bus.grant, 3'b010);
        chk("t5_switch_gid", bus.grant_id, 1);

        // 6: reset pulse mid-frame while granted
        pix(0);
        pix(1999);
        chk("t6_pre", bus.oled_data, 16'h001F);
        bus.pixel_index = 13'd2000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_grant", bus.grant, 3'b000);
        chk("t6_gid", bus.grant_id, 0);
        chk("t6_oled", bus.oled_data, 16'h0000);
        chk("t6_tick", bus.frame_tick, 0);
        pix(2001);
        chk("t6_idle", {bus.grant, bus.oled_data}, 0);
        pix(6143);
        chk("t6_regrant", bus.grant, 3'b010);
        chk("t6_regrant_tick", bus.frame_tick, 1);
        pix(0);
        chk("t6_oled_back", bus.oled_data, 16'h001F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
